// File: rtl/piso_shift_transmitter_if.sv
// Parallel-load / serial-out bus for piso_shift_transmitter.
// The master drives a word in; the slave shifts it out MSB first.
interface piso_shift_transmitter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, load_valid,
    input  load_ready, so, so_valid, last, busy
  );

  modport slave (
    input  din, load_valid,
    output load_ready, so, so_valid, last, busy
  );
endinterface

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word and emits it MSB first.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
module piso_shift_transmitter #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  piso_shift_transmitter_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  cnt_t             cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic so_c, so_valid_c, last_c, ready_c, accept_c;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    so_c       = 1'b0;
    so_valid_c = 1'b0;
    last_c     = 1'b0;

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        so_c       = sr_q[WIDTH-1];
        so_valid_c = 1'b1;
        sr_d       = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + cnt_t'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          last_c  = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        so_c       = parity_q;
        so_valid_c = 1'b1;
        last_c     = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A load in the last cycle overrides the end-of-frame transition, giving gapless frames.
    ready_c  = (state_q == IDLE) || last_c;
    accept_c = bus.load_valid && ready_c;
    if (accept_c) begin
      state_d  = SHIFT;
      sr_d     = bus.din;
      cnt_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^bus.din;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.so         = so_c;
  assign bus.so_valid   = so_valid_c;
  assign bus.last       = last_c;
  assign bus.load_ready = ready_c;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed bench for piso_shift_transmitter at WIDTH=8 and WIDTH=2 with a bit-level scoreboard.
// Works with or without PISO_PARITY_EN defined.
module tb_piso_shift_transmitter;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_shift_transmitter_if #(.WIDTH(8)) bus8 ();
  piso_shift_transmitter_if #(.WIDTH(2)) bus2 ();

  piso_shift_transmitter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  piso_shift_transmitter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct packed {
    logic so;
    logic last;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   tests = 0;
  int   fails = 0;
  bit   acc8_q, acc2_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q8.push_back('{so: w[i], last: (i == 0) && !PAR});
    if (PAR) q8.push_back('{so: ^w, last: 1'b1});
  endfunction

  function automatic void push2(input logic [1:0] w);
    for (int i = 1; i >= 0; i--) q2.push_back('{so: w[i], last: (i == 0) && !PAR});
    if (PAR) q2.push_back('{so: ^w, last: 1'b1});
  endfunction

  task automatic check_port(input string p, input logic so, input logic valid, input logic last,
                            input logic busy, input logic ready, input int qn, input exp_t head);
    logic e_so, e_valid, e_last, e_busy, e_ready;
    if (qn > 0) begin
      e_so = head.so; e_valid = 1'b1; e_last = head.last; e_busy = 1'b1; e_ready = head.last;
    end else begin
      e_so = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    end
    check({p, ".so"},         so,    e_so);
    check({p, ".so_valid"},   valid, e_valid);
    check({p, ".last"},       last,  e_last);
    check({p, ".busy"},       busy,  e_busy);
    check({p, ".load_ready"}, ready, e_ready);
  endtask

  // One clock: predict acceptance from the current head, advance the model, then compare.
  task automatic step();
    bit          acc8, acc2, r;
    logic [7:0]  d8;
    logic [1:0]  d2;
    exp_t        h8, h2;
    acc8 = bus8.load_valid && (q8.size() == 0 || q8[0].last);
    acc2 = bus2.load_valid && (q2.size() == 0 || q2[0].last);
    d8   = bus8.din;
    d2   = bus2.din;
    r    = rst;
    @(posedge clk);
    if (r) begin
      q8.delete();
      q2.delete();
      acc8 = 1'b0;
      acc2 = 1'b0;
    end else begin
      if (q8.size() > 0) void'(q8.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (acc8) push8(d8);
      if (acc2) push2(d2);
    end
    acc8_q = acc8;
    acc2_q = acc2;
    #1;
    h8 = (q8.size() > 0) ? q8[0] : '0;
    h2 = (q2.size() > 0) ? q2[0] : '0;
    check_port("w8", bus8.so, bus8.so_valid, bus8.last, bus8.busy, bus8.load_ready, q8.size(), h8);
    check_port("w2", bus2.so, bus2.so_valid, bus2.last, bus2.busy, bus2.load_ready, q2.size(), h2);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus8.load_valid = 1'b0; bus8.din = '0;
    bus2.load_valid = 1'b0; bus2.din = '0;

    // Reset, including a load request that reset must override.
    rst = 1'b1; bus8.load_valid = 1'b1; bus8.din = 8'hAA;
    step();
    bus8.load_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single frame of 8'hB5.
    bus8.load_valid = 1'b1; bus8.din = 8'hB5;
    step();
    bus8.load_valid = 1'b0; bus8.din = 8'h00;
    run(10);

    // Parity-zero word.
    bus8.load_valid = 1'b1; bus8.din = 8'h03;
    step();
    bus8.load_valid = 1'b0;
    run(10);

    // Back-to-back: second word held until accepted in the last cycle.
    bus8.load_valid = 1'b1; bus8.din = 8'hF0;
    step();
    bus8.din = 8'h0F;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc8_q && n < 20);
    check("b2b_accept", acc8_q, 1'b1);
    check("b2b_accept_cycle", n, PAR ? 9 : 8);
    bus8.load_valid = 1'b0;
    run(10);

    // Mid-frame reset after the third bit, then a fresh frame.
    bus8.load_valid = 1'b1; bus8.din = 8'hFF;
    step();
    bus8.load_valid = 1'b0;
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus8.load_valid = 1'b1; bus8.din = 8'h81;
    step();
    bus8.load_valid = 1'b0;
    run(10);

    // load_valid held while busy with din changing: the frame in flight must be unchanged.
    bus8.load_valid = 1'b1; bus8.din = 8'hA5;
    step();
    for (int i = 0; i < 7; i++) begin
      bus8.din = 8'($urandom);
      step();
    end
    bus8.load_valid = 1'b0;
    run(10);

    // A reset pulse between edges is ignored.
    bus8.load_valid = 1'b1; bus8.din = 8'h3C;
    step();
    bus8.load_valid = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    run(10);

    // WIDTH=2 single frame and back-to-back frames.
    bus2.load_valid = 1'b1; bus2.din = 2'b10;
    step();
    bus2.load_valid = 1'b0;
    run(4);
    bus2.load_valid = 1'b1; bus2.din = 2'b01;
    step();
    bus2.din = 2'b11;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc2_q && n < 10);
    check("w2_b2b_accept", acc2_q, 1'b1);
    bus2.load_valid = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_shift_transmitter.md
PISO_SHIFT_TRANSMITTER -- requirements
Module: piso_shift_transmitter

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame (legal 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: load_valid  input  1  din valid; a request to start a frame.
REQ-006 Port: load_ready  output  1  block can accept din this cycle.
REQ-007 Port: so  output  1  serial data out, MSB first, for a shift-left receiver's si.
REQ-008 Port: so_valid  output  1  so carries a frame bit this cycle.
REQ-009 Port: last  output  1  so carries the final bit of the current frame.
REQ-010 Port: busy  output  1  a frame is in progress (state != IDLE).

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT and PARITY (PARITY only with REQ-027).
REQ-012 A load SHALL be accepted on a rising edge where load_valid and load_ready are both 1; din is captured into a WIDTH-bit shift register on that edge.
REQ-013 load_ready SHALL be 1 in IDLE and in the cycle where last=1; it is 0 otherwise.
REQ-014 Latency: the first bit SHALL be on so (so=din[WIDTH-1], so_valid=1) in the cycle after the accepting edge.
REQ-015 In SHIFT, the register SHALL shift left by one bit per clock; so is always the register MSB; the LSB is filled with 0.
REQ-016 A bit counter of ceil(log2(WIDTH)) bits SHALL count emitted bits 0..WIDTH-1; last=1 when count=WIDTH-1 and no parity phase follows.
REQ-017 After WIDTH data bits the FSM SHALL go to IDLE, or to PARITY when REQ-027 applies.
REQ-018 A load accepted in the last=1 cycle SHALL start the next frame with no gap; the next frame's MSB appears in the following cycle.
REQ-019 In IDLE: so=0, so_valid=0, last=0, busy=0; load_valid is ignored whenever load_ready=0.
REQ-020 din SHALL be sampled only on the accepting edge; later din changes have no effect on the frame in flight.
REQ-021 so_valid SHALL be 1 in every SHIFT and PARITY cycle and 0 in IDLE.

Reset
REQ-022 With rst=1 on a clock edge, the FSM SHALL enter IDLE; the shift register and the counter clear to 0.
REQ-023 After reset: so=0, so_valid=0, last=0, busy=0, load_ready=1.
REQ-024 rst SHALL take priority over a simultaneous load; a frame in flight is aborted with no further bits emitted.
REQ-025 rst is sampled only on the clock edge; a pulse between edges has no effect.

Configuration
REQ-026 Macro PISO_PARITY_EN SHALL select an optional parity bit.
REQ-027 When PISO_PARITY_EN is defined, the FSM SHALL enter PARITY for one cycle after the data bits: so = XOR of the captured word (even parity), so_valid=1, last=1; frame length is WIDTH+1.
REQ-028 When PISO_PARITY_EN is not defined, the PARITY state and its logic SHALL be absent; last is asserted on the final data bit and the frame length is WIDTH.

Verification
REQ-029 After reset, load din=8'hB5 -> so=1,0,1,1,0,1,0,1 in cycles 1..8; so_valid=1 throughout; last=1 in cycle 8 only; then IDLE with so=0.
REQ-030 With PISO_PARITY_EN defined, load 8'hB5 -> the 8 data bits above, then so=1 in cycle 9 with last=1; load 8'h03 -> parity bit 0.
REQ-031 Back-to-back: load 8'hF0, then hold load_valid=1 with din=8'h0F -> the second load is accepted in the last=1 cycle; so reads 11110000 00001111 over 16 contiguous cycles with no so_valid gap.
REQ-032 Mid-frame reset: load 8'hFF, assert rst after the 3rd bit -> so_valid=0 and so=0 in the next cycle; load_ready=1; a new load of 8'h81 -> so=1,0,0,0,0,0,0,1.
REQ-033 load_valid held while busy, with din changing each cycle -> no new capture before last=1; the in-flight frame is unchanged.
REQ-034 WIDTH=2: load 2'b10 -> so=1,0 with last on the 2nd bit (or on the parity bit, value 1, when PISO_PARITY_EN is defined).
